// File: rtl/huff_pkg.sv
// Shared Huffman definitions: codebook entry layout, symbol width and the
// IDLE/RUN/FLUSH encoding common to the encoder and the decoder.
package huff_pkg;

    localparam int SYM_W    = 5;
    localparam int LEN_MSB  = 42;
    localparam int LEN_LSB  = 37;
    localparam int SRC_MSB  = 36;
    localparam int SRC_LSB  = 32;
    localparam int CODE_MSB = 31;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
    localparam int CODE_W   = CODE_MSB + 1;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Keeps the top `len` bits of a left-aligned code; len >= 32 keeps all.
    function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        return ~({CODE_W{1'b1}} >> len);
    endfunction

endpackage

// File: rtl/huff_enc_codebook.sv
// Symbol-indexed codebook: register table of {len, code} plus per-entry valid
// bits, written through the load handshake and read combinationally.
module huff_enc_codebook #(
    parameter int SYM_W = huff_pkg::SYM_W
) (
    input  logic                        clk,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [SYM_W-1:0]            wr_src_i,
    input  logic [huff_pkg::LEN_W-1:0]  wr_len_i,
    input  logic [huff_pkg::CODE_W-1:0] wr_code_i,
    input  logic [SYM_W-1:0]            rd_sym_i,
    output logic                        rd_valid_o,
    output logic [huff_pkg::LEN_W-1:0]  rd_len_o,
    output logic [huff_pkg::CODE_W-1:0] rd_code_o
);
    import huff_pkg::*;

    localparam int DEPTH = 1 << SYM_W;

    logic [LEN_W+CODE_W-1:0] table_q [DEPTH];
    logic [DEPTH-1:0]        valid_q;

    // NOTE: the table itself is not reset; only the valid bits are, which is
    // enough to make every entry read as unloaded and keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            table_q[wr_src_i] <= {wr_len_i, wr_code_i & len_mask(wr_len_i)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_src_i] <= 1'b1;
        end
    end

    assign rd_valid_o = valid_q[rd_sym_i];
    assign rd_len_o   = table_q[rd_sym_i][LEN_W+CODE_W-1:CODE_W];
    assign rd_code_o  = table_q[rd_sym_i][CODE_W-1:0];

endmodule

// File: rtl/huffman_encoder.sv
// Huffman encoder: looks symbols up in the codebook, packs codes MSB-first
// into a 64-bit accumulator and hands out 32-bit words over buf_valid/buf_ready.
module huffman_encoder #(
    parameter int CB_W  = 43,
    parameter int SYM_W = huff_pkg::SYM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CB_W-1:0]  codebook_data,
    input  logic             WVALID,
    output logic             WREADY,
    input  logic             start,
    input  logic             flush,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic [31:0]      data,
    output logic             buf_valid,
    input  logic             buf_ready,
    output logic [31:0]      bit_count,
    output logic             done,
    output logic             err
);
    import huff_pkg::*;

    state_t              state_q, state_d;
    logic [63:0]         acc_q, acc_d;
    logic [6:0]          fill_q, fill_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                buf_valid_q, buf_valid_d;
    logic [31:0]         bit_count_q, bit_count_d;
    logic                err_q, err_d;
    logic                wready_q;

    logic                cb_we;
    logic                rd_valid;
    logic [LEN_W-1:0]    rd_len;
    logic [CODE_W-1:0]   rd_code;

    logic                slot_free;
    logic                full_emit;
    logic                part_emit;
    logic                sym_fire;
    logic                sym_good;
    logic                flush_done;
    logic [63:0]         acc_s;
    logic [6:0]          fill_s;

    assign cb_we = WVALID && wready_q;

    huff_enc_codebook #(
        .SYM_W (SYM_W)
    ) u_codebook (
        .clk        (clk),
        .rst_ni     (rst),
        .wr_en_i    (cb_we),
        .wr_src_i   (codebook_data[SRC_MSB:SRC_LSB]),
        .wr_len_i   (codebook_data[LEN_MSB:LEN_LSB]),
        .wr_code_i  (codebook_data[CODE_MSB:0]),
        .rd_sym_i   (sym_in),
        .rd_valid_o (rd_valid),
        .rd_len_o   (rd_len),
        .rd_code_o  (rd_code)
    );

    assign slot_free  = !buf_valid_q || buf_ready;
    assign full_emit  = (fill_q >= 7'd32) && slot_free;
    assign part_emit  = (state_q == FLUSH) && (fill_q != 7'd0) && (fill_q < 7'd32) && slot_free;
    assign sym_ready  = (state_q == RUN) && ((fill_q < 7'd32) || slot_free);
    assign sym_fire   = sym_valid && sym_ready;
    // Lengths above 32 cannot be represented by a 32-bit code, so they count as bad too.
    assign sym_good   = rd_valid && (rd_len != '0) && (rd_len <= 6'd32);
    assign flush_done = (state_q == FLUSH) && (fill_q == 7'd0) && !buf_valid_q;

    // NOTE: every signal driven here gets its default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = RUN;
            RUN:     if (flush)      state_d = FLUSH;
            FLUSH:   if (flush_done) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        data_d      = data_q;
        buf_valid_d = buf_valid_q;
        bit_count_d = bit_count_q;
        err_d       = err_q;

        // Post-emit view of the accumulator; a same-cycle append lands behind it.
        acc_s  = acc_q;
        fill_s = fill_q;
        if (full_emit) begin
            acc_s  = {acc_q[31:0], 32'b0};
            fill_s = fill_q - 7'd32;
        end else if (part_emit) begin
            acc_s  = '0;
            fill_s = '0;
        end
        acc_d  = acc_s;
        fill_d = fill_s;

        if (sym_fire) begin
            if (sym_good) begin
                acc_d       = acc_s | ({rd_code, 32'b0} >> fill_s);
                fill_d      = fill_s + {1'b0, rd_len};
                bit_count_d = bit_count_q + {26'b0, rd_len};
            end else begin
                err_d = 1'b1;
            end
        end

        if (full_emit || part_emit) begin
            data_d      = acc_q[63:32];
            buf_valid_d = 1'b1;
        end else if (buf_ready) begin
            buf_valid_d = 1'b0;
        end

        if ((state_q == IDLE) && start) begin
            bit_count_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            fill_q      <= '0;
            data_q      <= '0;
            buf_valid_q <= 1'b0;
            bit_count_q <= '0;
            err_q       <= 1'b0;
            wready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            buf_valid_q <= buf_valid_d;
            bit_count_q <= bit_count_d;
            err_q       <= err_d;
            wready_q    <= (state_d == IDLE);
        end
    end

    assign WREADY    = wready_q;
    assign data      = data_q;
    assign buf_valid = buf_valid_q;
    assign bit_count = bit_count_q;
    assign done      = flush_done;
    assign err       = err_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: directed scenarios plus a random run,
// compared against a bit-queue reference model of the packing rules.
module tb_huffman_encoder;

    logic        clk;
    logic        rst;
    logic [42:0] codebook_data;
    logic        WVALID;
    logic        WREADY;
    logic        start;
    logic        flush;
    logic [4:0]  sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic [31:0] data;
    logic        buf_valid;
    logic        buf_ready;
    logic [31:0] bit_count;
    logic        done;
    logic        err;

    huffman_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .codebook_data (codebook_data),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .start         (start),
        .flush         (flush),
        .sym_in        (sym_in),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .data          (data),
        .buf_valid     (buf_valid),
        .buf_ready     (buf_ready),
        .bit_count     (bit_count),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference codebook and scoreboard state
    logic        m_valid [32];
    logic [5:0]  m_len   [32];
    logic [31:0] m_code  [32];
    logic        err_exp;
    logic [31:0] got_words [$];
    logic [4:0]  acc_syms  [$];
    int          cyc = 0;
    int          bv_cycles = 0;
    int          last_hs = 0;
    int          done_cyc = 0;
    bit          rand_bp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (buf_valid) bv_cycles++;
            if (buf_valid && buf_ready) begin
                got_words.push_back(data);
                last_hs = cyc;
            end
            if (sym_valid && sym_ready) acc_syms.push_back(sym_in);
            if (done) done_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cb_write(input logic [4:0] src, input logic [5:0] len, input logic [31:0] code);
        int n;
        bit ok;
        n  = 0;
        ok = 1;
        codebook_data = {len, src, code};
        WVALID = 1'b1;
        forever begin
            @(negedge clk);
            if (WREADY) break;
            n++;
            if (n > 50) begin
                check("wready_timeout", 64'(WREADY), 64'd1);
                ok = 0;
                break;
            end
        end
        tick();
        WVALID = 1'b0;
        if (ok) begin
            m_valid[src] = 1'b1;
            m_len[src]   = len;
            m_code[src]  = code;
        end
    endtask

    task automatic load_base();
        cb_write(5'd0, 6'd1, 32'h7FFF_FFFF);   // '0', junk below the code
        cb_write(5'd1, 6'd2, 32'hBFFF_FFFF);   // '10'
        cb_write(5'd2, 6'd2, 32'hC001_2345);   // '11'
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_sym(input logic [4:0] s);
        int n;
        n = 0;
        sym_in    = s;
        sym_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sym_ready) break;
            n++;
            if (n > 200) begin
                check("sym_ready_timeout", 64'(sym_ready), 64'd1);
                break;
            end
            tick();
            if (rand_bp) buf_ready = 1'($urandom_range(0, 1));
        end
        tick();
        sym_valid = 1'b0;
        if (rand_bp) buf_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic flush_wait(input string tag);
        int n;
        n = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 200) begin
                check({tag, "_done_timeout"}, 64'(done), 64'd1);
                break;
            end
        end
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_wready"}, 64'(WREADY), 64'd1);
    endtask

    // Rebuild the expected word stream from the accepted symbols and compare.
    task automatic check_run(input string tag);
        bit          bits [$];
        logic [31:0] w;
        logic [31:0] nbits;
        int          nexp;
        int          s;
        nbits = 0;
        foreach (acc_syms[k]) begin
            s = int'(acc_syms[k]);
            if (m_valid[s] && m_len[s] != 6'd0) begin
                for (int i = 0; i < int'(m_len[s]); i++) bits.push_back(m_code[s][31-i]);
                nbits += 32'(m_len[s]);
            end else begin
                err_exp = 1'b1;
            end
        end
        nexp = (bits.size() + 31) / 32;
        check({tag, "_nwords"}, 64'(got_words.size()), 64'(nexp));
        for (int k = 0; k < nexp; k++) begin
            w = '0;
            for (int i = 0; i < 32; i++) if (bits.size() > 0) w[31-i] = bits.pop_front();
            if (k < got_words.size()) check($sformatf("%s_word%0d", tag, k), 64'(got_words[k]), 64'(w));
        end
        check({tag, "_bitcount"}, 64'(bit_count), 64'(nbits));
        check({tag, "_err"}, 64'(err), 64'(err_exp));
        got_words.delete();
        acc_syms.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wready"},    64'(WREADY),    64'd0);
        check({tag, "_sym_ready"}, 64'(sym_ready), 64'd0);
        check({tag, "_buf_valid"}, 64'(buf_valid), 64'd0);
        check({tag, "_data"},      64'(data),      64'd0);
        check({tag, "_bit_count"}, 64'(bit_count), 64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
    endtask

    initial begin
        rst = 1'b0; codebook_data = '0; WVALID = 1'b0; start = 1'b0; flush = 1'b0;
        sym_in = '0; sym_valid = 1'b0; buf_ready = 1'b1; err_exp = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_len[i] = '0; m_code[i] = '0;
        end

        // Reset state
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        check("reset_wready_up", 64'(WREADY), 64'd1);
        load_base();

        // 32 x '0' -> one zero word
        start_run();
        repeat (32) send_sym(5'd0);
        repeat (3) tick();
        flush_wait("t1");
        check_run("t1");

        // 16 x '10' -> 0xAAAAAAAA, buf_valid for exactly one cycle
        start_run();
        bv_cycles = 0;
        repeat (16) send_sym(5'd1);
        repeat (3) tick();
        flush_wait("t2");
        check("t2_valid_cycles", 64'(bv_cycles), 64'd1);
        check_run("t2");

        // '11', then '0' accepted together with flush -> 0xC0000000
        start_run();
        send_sym(5'd2);
        sym_in = 5'd0; sym_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("t3_sym_with_flush", 64'(sym_ready), 64'd1);
        tick();
        sym_valid = 1'b0;
        flush_wait("t3");
        check("t3_done_latency", 64'(done_cyc - last_hs), 64'd1);
        check_run("t3");

        // 48 x '10' under backpressure
        start_run();
        buf_ready = 1'b0;
        repeat (32) send_sym(5'd1);
        sym_in = 5'd1; sym_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("t4_stall_sym_ready", 64'(sym_ready), 64'd0);
        check("t4_stall_buf_valid", 64'(buf_valid), 64'd1);
        check("t4_stall_accepted", 64'(acc_syms.size()), 64'd32);
        tick();
        buf_ready = 1'b1;
        repeat (16) send_sym(5'd1);
        repeat (3) tick();
        flush_wait("t4");
        check_run("t4");

        // Unloaded symbol 7 sets err and adds nothing
        start_run();
        send_sym(5'd7);
        tick();
        check("t5_err", 64'(err), 64'd1);
        check("t5_bitcount", 64'(bit_count), 64'd0);
        send_sym(5'd1);
        flush_wait("t5");
        check_run("t5");

        // Random codebook and symbols with random backpressure
        for (int s = 3; s < 23; s++) cb_write(5'(s), 6'($urandom_range(1, 32)), $urandom);
        cb_write(5'd23, 6'd0, $urandom);
        start_run();
        rand_bp = 1;
        for (int i = 0; i < 150; i++) send_sym(5'($urandom_range(0, 25)));
        rand_bp = 0;
        buf_ready = 1'b1;
        repeat (3) tick();
        flush_wait("rand");
        check_run("rand");

        // Reset mid-run with a word pending
        start_run();
        buf_ready = 1'b0;
        repeat (16) send_sym(5'd1);
        repeat (3) tick();
        check("t6_pending", 64'(buf_valid), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_outputs("t6_reset");
        got_words.delete();
        acc_syms.delete();
        err_exp = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        buf_ready = 1'b1;
        repeat (3) tick();
        check("t6_sym_ready_idle", 64'(sym_ready), 64'd0);
        // Codebook contents were discarded by the reset
        start_run();
        send_sym(5'd0);
        tick();
        check("t6_cleared_err", 64'(err), 64'd1);
        flush_wait("t6a");
        check_run("t6a");
        load_base();
        start_run();
        send_sym(5'd2);
        send_sym(5'd0);
        flush_wait("t6b");
        check_run("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
